// File: rtl/ifetch_pkg.sv
// Shared state encoding and sizing constants for the byte-serial instruction fetch path.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    localparam int LANE_W  = 4;
    localparam int BYTE_W  = 8;
    localparam int PC_STEP = 4;

    // Little-endian lane select: byte k of the word lands in lane k.
    function automatic logic [LANE_W-1:0] lane_strobe(input logic [1:0] idx);
        lane_strobe = LANE_W'(1) << idx;
    endfunction

endpackage

// File: rtl/ifetch_wait_timer.sv
// Counts consecutive stalled cycles of one byte read and flags the cycle on which
// the stall budget runs out; a TIMEOUT of 0 never expires.
module ifetch_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int               CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit               ENABLED = (TIMEOUT != 0);

    logic [CNT_W-1:0] count_q;

    // Expiry is seen on the stalled edge that would bring the count up to TIMEOUT.
    assign expired_o = ENABLED && count_en_i && (count_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i || expired_o) begin
            count_q <= '0;
        end else if (count_en_i && ENABLED) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ifetch_byte_sequencer.sv
// Byte-serial instruction fetch: reads one 32-bit instruction as four byte reads,
// strobes each byte into its lane of the instruction register and owns the PC.
module ifetch_byte_sequencer
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req_i,
    input  logic              pc_load_i,
    input  logic [ADDR_W-1:0] pc_in_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    input  logic              mem_ready_i,
    input  logic [BYTE_W-1:0] mem_rdata_i,
    output logic [BYTE_W-1:0] data_out_o,
    output logic [LANE_W-1:0] inst_write_o,
    output logic              fetch_busy_o,
    output logic              fetch_done_o,
    output logic              fetch_err_o,
    output logic [ADDR_W-1:0] pc_out_o
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        k_q;
    logic [BYTE_W-1:0] data_q;
    logic [LANE_W-1:0] strobe_q;
    logic              done_q;
    logic              err_q;

    logic              reading;
    logic              stall;
    logic              expired;

    assign reading = (state_q == ST_READ);
    assign stall   = reading && !mem_ready_i;

    ifetch_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_en_i (stall),
        .clear_i    (!stall),
        .expired_o  (expired)
    );

    // The memory interface is decoded straight from state so an async reset drops mem_rd at once.
    assign mem_rd_o     = reading;
    assign mem_addr_o   = reading ? (base_q + ADDR_W'(k_q)) : '0;
    assign fetch_busy_o = (state_q != ST_IDLE);
    assign data_out_o   = data_q;
    assign inst_write_o = strobe_q;
    assign fetch_done_o = done_q;
    assign fetch_err_o  = err_q;
    assign pc_out_o     = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            base_q   <= '0;
            k_q      <= '0;
            data_q   <= '0;
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            strobe_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pc_load_i) begin
                        pc_q <= pc_in_i;
                    end else if (fetch_req_i) begin
                        base_q  <= pc_q;
                        k_q     <= '0;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (mem_ready_i) begin
                        data_q   <= mem_rdata_i;
                        strobe_q <= lane_strobe(k_q);
                        if (k_q == 2'd3) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            k_q <= k_q + 2'd1;
                        end
                    end else if (expired) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    pc_q    <= base_q + ADDR_W'(PC_STEP);
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
